// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states,
// the latched request payload and byte-lane shift helpers.
package mem_access_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned SHIFT_W = 5;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Request fields captured at acceptance
    typedef struct packed {
        logic                  we;
        logic [SIZE_W-1:0]     size;
        logic                  sign;
        logic [LANE_IDX_W-1:0] lane;
        logic [WORD_W-1:0]     wdata;
    } req_lat_t;

    // Bit offset of byte lane k (little-endian)
    function automatic logic [SHIFT_W-1:0] lane_shift(input logic [LANE_IDX_W-1:0] lane);
        return {lane, 3'b000};
    endfunction

    // Bit offset of the half selected by addr[1]
    function automatic logic [SHIFT_W-1:0] half_shift(input logic hi);
        return {hi, 4'b0000};
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic.
//   old_word    : current memory word
//   wdata       : right-aligned store data
//   size/lane   : access size and addr[1:0]
//   sign        : sign-extend loads
//   merged_c    : old_word with addressed lanes replaced by wdata
//   extracted_c : addressed lanes shifted to bit 0, sign/zero extended
module mem_lane_merge
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0]     old_word,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [SIZE_W-1:0]     size,
    input  logic [LANE_IDX_W-1:0] lane,
    input  logic                  sign,
    output logic [WORD_W-1:0]     merged_c,
    output logic [WORD_W-1:0]     extracted_c
);

    logic [LANE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        merged_c    = old_word;
        extracted_c = '0;
        byte_sel    = LANE_W'(old_word >> lane_shift(lane));
        half_sel    = HALF_W'(old_word >> half_shift(lane[1]));
        case (size)
            SZ_BYTE: begin
                merged_c[lane_shift(lane) +: LANE_W] = wdata[LANE_W-1:0];
                extracted_c = {{(WORD_W-LANE_W){sign & byte_sel[LANE_W-1]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_c[half_shift(lane[1]) +: HALF_W] = wdata[HALF_W-1:0];
                extracted_c = {{(WORD_W-HALF_W){sign & half_sel[HALF_W-1]}}, half_sel};
            end
            SZ_WORD: begin
                merged_c    = wdata;
                extracted_c = old_word;
            end
            default: begin
                merged_c    = old_word;
                extracted_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed memory with async read and
// sync write. Sub-word stores are read-modify-write.
//   CLK, RST             : clock, async active-low reset
//   req_*                : load/store request handshake and fields
//   resp_valid/rdata/err : one-cycle completion pulse with load data or error
//   mem_a/mem_wd/mem_we  : memory word index, write data, write enable
//   mem_rd               : combinational read data of mem_a
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 40000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    state_t                state;
    req_lat_t              lat;
    logic                  err_c;
    logic [ADDR_WIDTH-1:0] word_idx_c;
    logic [WORD_W-1:0]     merged_c;
    logic [WORD_W-1:0]     extracted_c;

    // Ready is forced low while reset is held
    assign req_ready  = (state == ST_IDLE) && RST;
    assign word_idx_c = req_addr >> 2;

    // Request error decode: alignment, illegal size, range
    always_comb begin
        err_c = 1'b0;
        case (req_size)
            SZ_BYTE: err_c = 1'b0;
            SZ_HALF: err_c = req_addr[0];
            SZ_WORD: err_c = |req_addr[1:0];
            default: err_c = 1'b1;
        endcase
        if (word_idx_c >= DEPTH_W) begin
            err_c = 1'b1;
        end
    end

    // Lane logic always works on the latched request and live memory data
    mem_lane_merge u_lane (
        .old_word    (mem_rd),
        .wdata       (lat.wdata),
        .size        (lat.size),
        .lane        (lat.lane),
        .sign        (lat.sign),
        .merged_c    (merged_c),
        .extracted_c (extracted_c)
    );

    // Control FSM; response and write-enable are single-cycle pulses by default
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            lat        <= '0;
            mem_a      <= '0;
            mem_wd     <= '0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat.we    <= req_we;
                        lat.size  <= req_size;
                        lat.sign  <= req_sign;
                        lat.lane  <= req_addr[1:0];
                        lat.wdata <= WORD_W'(req_wdata);
                        mem_a     <= word_idx_c;
                        if (err_c) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            // Full-word store skips the read phase
                            mem_wd <= req_wdata;
                            mem_we <= 1'b1;
                            state  <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (lat.we) begin
                        mem_wd <= DATA_WIDTH'(merged_c);
                        mem_we <= 1'b1;
                        state  <= ST_WR;
                    end else begin
                        resp_rdata <= DATA_WIDTH'(extracted_c);
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
